jtag_shift_engine: RTL and testbench

- Parametrised VME-driven JTAG shift engine; successor to the fixed 16-bit per-chain shifters behind the CFEB, control-FPGA and PROM JTAG address blocks.
- Serves NCHAN chains from one engine: per-chain TCK gating, common TMS/TDI, muxed TDO.
- Adds a programmable TCK divider, separate IR/DR header and trailer sequencing, a TAP reset command, and variable shift length up to DW bits.
- Sits between the VME address decoder (command/data) and the board JTAG pins.

---
 rtl/jtag_pkg.sv | 24 ++
 rtl/jtag_tck_phase.sv | 40 ++++
 rtl/jtag_shift_engine.sv | 171 +++++++++++++++++
 tb/tb_jtag_shift_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG shift engine: sequencer states and TMS patterns.
// Patterns are stored LSB-first, so bit k is the TMS value for bit k of the sequence.
package jtag_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_HDR,
        S_SHIFT,
        S_TLR,
        S_DONE
    } state_t;

    localparam logic [7:0]  TMS_RST    = 8'b0001_1111;
    localparam logic [7:0]  TMS_IR_HDR = 8'b0000_0011;
    localparam logic [7:0]  TMS_DR_HDR = 8'b0000_0001;
    localparam logic [7:0]  TMS_TLR    = 8'b0000_0001;

    localparam int unsigned LEN_RST    = 6;
    localparam int unsigned LEN_IR_HDR = 4;
    localparam int unsigned LEN_DR_HDR = 3;
    localparam int unsigned LEN_TLR    = 2;

endpackage

// File: rtl/jtag_tck_phase.sv
// TCK bit-period divider. Count 0 is a one-clock setup slot after accept; the
// count then cycles 1..2*TCK_DIV, and the last count doubles as the next low start.
module jtag_tck_phase #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic low_start_o,
    output logic rise_o,
    output logic period_end_o
);

    localparam int unsigned PER = 2 * TCK_DIV;
    localparam int unsigned CW  = $clog2(PER + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i)
            cnt_d = '0;
        else if (cnt_q == CW'(PER))
            cnt_d = CW'(1);
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign period_end_o = en_i && (cnt_q == CW'(PER));
    assign low_start_o  = en_i && ((cnt_q == '0) || (cnt_q == CW'(PER)));
    assign rise_o       = en_i && (cnt_q == CW'(TCK_DIV));

endmodule

// File: rtl/jtag_shift_engine.sv
// VME-driven multi-chain JTAG shift engine with header/trailer sequencing,
// TAP reset command and programmable TCK divider.
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int unsigned NCHAN   = 5,
    parameter int unsigned DW      = 16,
    parameter int unsigned TCK_DIV = 2,
    parameter int unsigned LW      = $clog2(DW)
) (
    input  logic             FPGACLK,
    input  logic             RST_B,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [LW-1:0]    CMD_LEN,
    input  logic             CMD_HDR,
    input  logic             CMD_IR,
    input  logic             CMD_TLR,
    input  logic             CMD_RST,
    input  logic [DW-1:0]    CMD_DATA,
    input  logic [NCHAN-1:0] CHAN_SEL,
    input  logic [NCHAN-1:0] TDO_IN,
    output logic [NCHAN-1:0] TCK,
    output logic             TMS,
    output logic             TDI,
    output logic [DW-1:0]    TDO_DATA,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned BW = (LW > 3) ? LW : 3;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [LW-1:0]    len_q;
    logic             ir_q, tlr_q;
    logic [DW-1:0]    data_q, cap_q, tdo_data_q;
    logic [NCHAN-1:0] sel_q;
    logic             tck_q, tms_q, tdi_q;
    logic             tms_nxt, tdi_nxt, tdo_bit, last, accept;
    logic             low_start, rise, period_end;

    jtag_tck_phase #(.TCK_DIV(TCK_DIV)) u_phase (
        .clk_i        (FPGACLK),
        .rst_ni       (RST_B),
        .en_i         (BUSY),
        .low_start_o  (low_start),
        .rise_o       (rise),
        .period_end_o (period_end)
    );

    assign accept = CMD_VALID && CMD_READY;

    always_ff @(posedge FPGACLK) begin
        if (!RST_B) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        last = 1'b0;
        case (state_q)
            S_RST:   last = (bit_q == BW'(LEN_RST - 1));
            S_HDR:   last = (bit_q == (ir_q ? BW'(LEN_IR_HDR - 1) : BW'(LEN_DR_HDR - 1)));
            S_SHIFT: last = (bit_q == BW'(len_q));
            S_TLR:   last = (bit_q == BW'(LEN_TLR - 1));
            default: last = 1'b0;
        endcase

        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                bit_d   = '0;
                if (accept)
                    state_d = CMD_RST ? S_RST : (CMD_HDR ? S_HDR : S_SHIFT);
            end
            default: begin
                if (period_end) begin
                    bit_d = last ? '0 : bit_q + 1'b1;
                    if (last) begin
                        case (state_q)
                            S_HDR:   state_d = S_SHIFT;
                            S_SHIFT: state_d = tlr_q ? S_TLR : S_DONE;
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        CMD_READY = (state_q == S_IDLE) || (state_q == S_DONE);
        BUSY      = !CMD_READY;
        DONE      = (state_q == S_DONE);
    end

    // TMS/TDI are loaded for the bit about to start, hence decoded from the next state.
    always_comb begin
        tms_nxt = tms_q;
        tdi_nxt = tdi_q;
        case (state_d)
            S_RST:   begin tms_nxt = TMS_RST[bit_d[2:0]]; tdi_nxt = 1'b0; end
            S_HDR:   begin
                tms_nxt = ir_q ? TMS_IR_HDR[bit_d[2:0]] : TMS_DR_HDR[bit_d[2:0]];
                tdi_nxt = 1'b0;
            end
            S_SHIFT: begin
                tms_nxt = tlr_q && (bit_d == BW'(len_q));
                tdi_nxt = data_q[bit_d[LW-1:0]];
            end
            S_TLR:   begin tms_nxt = TMS_TLR[bit_d[2:0]]; tdi_nxt = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        tdo_bit = 1'b0;
        for (int unsigned i = NCHAN; i > 0; i--)
            if (sel_q[i-1])
                tdo_bit = TDO_IN[i-1];
    end

    always_ff @(posedge FPGACLK) begin
        if (!RST_B) begin
            len_q      <= '0;
            ir_q       <= 1'b0;
            tlr_q      <= 1'b0;
            data_q     <= '0;
            sel_q      <= '0;
            cap_q      <= '0;
            tdo_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
        end else begin
            if (accept) begin
                len_q  <= CMD_LEN;
                ir_q   <= CMD_IR;
                tlr_q  <= CMD_TLR;
                data_q <= CMD_DATA;
                sel_q  <= CHAN_SEL;
                cap_q  <= '0;
            end
            if (low_start) begin
                tck_q <= 1'b0;
                tms_q <= tms_nxt;
                tdi_q <= tdi_nxt;
            end
            if (rise) begin
                tck_q <= 1'b1;
                if (state_q == S_SHIFT)
                    cap_q[bit_q[LW-1:0]] <= tdo_bit;
            end
            if (period_end && last && (state_d == S_DONE))
                tdo_data_q <= cap_q;
        end
    end

    assign TCK      = tck_q ? sel_q : '0;
    assign TMS      = tms_q;
    assign TDI      = tdi_q;
    assign TDO_DATA = tdo_data_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine: TMS/TDI sequences, loopback capture,
// completion timing, busy-ignore and mid-command reset.
module tb_jtag_shift_engine;

    logic        FPGACLK;
    logic        RST_B;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [3:0]  CMD_LEN;
    logic        CMD_HDR, CMD_IR, CMD_TLR, CMD_RST;
    logic [15:0] CMD_DATA;
    logic [4:0]  CHAN_SEL;
    logic [4:0]  TDO_IN;
    logic [4:0]  TCK;
    logic        TMS, TDI;
    logic [15:0] TDO_DATA;
    logic        BUSY, DONE;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned src      = 0;
    logic        loop_q   = 1'b0;

    jtag_shift_engine #(.NCHAN(5), .DW(16), .TCK_DIV(2)) dut (
        .FPGACLK   (FPGACLK),
        .RST_B     (RST_B),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_LEN   (CMD_LEN),
        .CMD_HDR   (CMD_HDR),
        .CMD_IR    (CMD_IR),
        .CMD_TLR   (CMD_TLR),
        .CMD_RST   (CMD_RST),
        .CMD_DATA  (CMD_DATA),
        .CHAN_SEL  (CHAN_SEL),
        .TDO_IN    (TDO_IN),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO_DATA  (TDO_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial FPGACLK = 1'b0;
    always #5 FPGACLK = ~FPGACLK;

    // Loopback on the chosen source chain, inverted data elsewhere to expose a wrong mux.
    always @(posedge FPGACLK) loop_q <= TDI;
    always_comb begin
        for (int i = 0; i < 5; i++)
            TDO_IN[i] = (i == int'(src)) ? loop_q : ~loop_q;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

    task automatic run_cmd(input logic rst, input logic hdr, input logic ir, input logic tlr,
                           input logic [3:0] len, input logic [15:0] data, input logic [4:0] sel,
                           input int unsigned poke, input int unsigned budget,
                           output int unsigned done_cyc, output int unsigned ndone,
                           output int unsigned nrise, output logic [31:0] tms_seq,
                           output logic [31:0] tdi_seq, output logic tck_bad, output logic rdy_bad);
        logic [4:0] prev, rise;
        done_cyc = 0; ndone = 0; nrise = 0;
        tms_seq = '0; tdi_seq = '0; tck_bad = 1'b0; rdy_bad = 1'b0;
        for (int w = 0; w < 20 && !CMD_READY; w++) begin
            @(posedge FPGACLK); #1;
        end
        CMD_RST = rst; CMD_HDR = hdr; CMD_IR = ir; CMD_TLR = tlr;
        CMD_LEN = len; CMD_DATA = data; CHAN_SEL = sel; CMD_VALID = 1'b1;
        @(posedge FPGACLK); #1;
        CMD_VALID = 1'b0;
        CHAN_SEL  = 5'b11111;
        prev = TCK;
        for (int unsigned n = 1; n <= budget + 8; n++) begin
            @(posedge FPGACLK); #1;
            if (DONE) begin
                ndone++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (done_cyc == 0 && (CMD_READY || !BUSY)) rdy_bad = 1'b1;
            rise = TCK & ~prev;
            if ((TCK & ~sel) != 5'b0) tck_bad = 1'b1;
            if (rise != 5'b0) begin
                if (rise != sel) tck_bad = 1'b1;
                if (nrise < 32) begin
                    tms_seq[nrise] = TMS;
                    tdi_seq[nrise] = TDI;
                end
                nrise++;
            end
            prev = TCK;
            if (poke != 0 && n == poke) begin
                CMD_VALID = 1'b1; CMD_RST = 1'b1; CMD_LEN = 4'hF; CMD_DATA = 16'hFFFF;
            end
            if (poke != 0 && n == poke + 1) CMD_VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST_B = 1'b0; CMD_VALID = 1'b0; CMD_LEN = '0; CMD_HDR = 0; CMD_IR = 0;
        CMD_TLR = 0; CMD_RST = 0; CMD_DATA = '0; CHAN_SEL = '0;
        repeat (5) @(posedge FPGACLK);
        #1;
        checks++; if (TCK !== 5'b0) begin failures++; $display("FAIL reset_tck got=%b exp=00000", TCK); end
        checks++; if (TMS !== 1'b0) begin failures++; $display("FAIL reset_tms got=%b exp=0", TMS); end
        checks++; if (TDI !== 1'b0) begin failures++; $display("FAIL reset_tdi got=%b exp=0", TDI); end
        checks++; if (TDO_DATA !== 16'h0) begin failures++; $display("FAIL reset_tdo_data got=%h exp=0000", TDO_DATA); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
        checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
        RST_B = 1'b1;
        @(posedge FPGACLK); #1;
    endtask

    task automatic test_dr_loopback();
        int unsigned dc, nd, nr;
        logic [31:0] tms_s, tdi_s;
        logic tb, rb;
        src = 2;
        run_cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 16'h01A5, 5'b00100, 0, 60, dc, nd, nr, tms_s, tdi_s, tb, rb);
        checks++; if (dc !== 57) begin failures++; $display("FAIL dr_done_cycle got=%0d exp=57", dc); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL dr_done_pulses got=%0d exp=1", nd); end
        checks++; if (nr !== 14) begin failures++; $display("FAIL dr_tck_rises got=%0d exp=14", nr); end
        checks++; if (tms_s !== 32'h0000_1801) begin failures++; $display("FAIL dr_tms_seq got=%h exp=00001801", tms_s); end
        checks++; if (tdi_s !== 32'h0000_0D28) begin failures++; $display("FAIL dr_tdi_seq got=%h exp=00000d28", tdi_s); end
        checks++; if (TDO_DATA !== 16'h01A5) begin failures++; $display("FAIL dr_tdo_data got=%h exp=01a5", TDO_DATA); end
        checks++; if (tb !== 1'b0) begin failures++; $display("FAIL dr_tck_gating got=%b exp=0", tb); end
        checks++; if (rb !== 1'b0) begin failures++; $display("FAIL dr_ready_busy got=%b exp=0", rb); end
    endtask

    task automatic test_ir_full();
        int unsigned dc, nd, nr;
        logic [31:0] tms_s, tdi_s;
        logic tb, rb;
        src = 1;
        run_cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 16'hC3A5, 5'b01010, 0, 84, dc, nd, nr, tms_s, tdi_s, tb, rb);
        checks++; if (dc !== 81) begin failures++; $display("FAIL ir_done_cycle got=%0d exp=81", dc); end
        checks++; if (nr !== 20) begin failures++; $display("FAIL ir_tck_rises got=%0d exp=20", nr); end
        checks++; if (tms_s !== 32'h0000_0003) begin failures++; $display("FAIL ir_tms_seq got=%h exp=00000003", tms_s); end
        checks++; if (tdi_s !== 32'h000C_3A50) begin failures++; $display("FAIL ir_tdi_seq got=%h exp=000c3a50", tdi_s); end
        checks++; if (TDO_DATA !== 16'hC3A5) begin failures++; $display("FAIL ir_tdo_data got=%h exp=c3a5", TDO_DATA); end
        checks++; if (tb !== 1'b0) begin failures++; $display("FAIL ir_tck_gating got=%b exp=0", tb); end
    endtask

    task automatic test_tap_reset();
        int unsigned dc, nd, nr;
        logic [31:0] tms_s, tdi_s;
        logic tb, rb;
        src = 0;
        run_cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 16'hFFFF, 5'b11111, 0, 28, dc, nd, nr, tms_s, tdi_s, tb, rb);
        checks++; if (dc !== 25) begin failures++; $display("FAIL rst_done_cycle got=%0d exp=25", dc); end
        checks++; if (nr !== 6) begin failures++; $display("FAIL rst_tck_rises got=%0d exp=6", nr); end
        checks++; if (tms_s !== 32'h0000_001F) begin failures++; $display("FAIL rst_tms_seq got=%h exp=0000001f", tms_s); end
        checks++; if (tdi_s !== 32'h0) begin failures++; $display("FAIL rst_tdi_seq got=%h exp=00000000", tdi_s); end
        checks++; if (tb !== 1'b0) begin failures++; $display("FAIL rst_all_tck got=%b exp=0", tb); end
        checks++; if (TDO_DATA !== 16'h0) begin failures++; $display("FAIL rst_tdo_data got=%h exp=0000", TDO_DATA); end
    endtask

    task automatic test_busy_ignore();
        int unsigned dc, nd, nr;
        logic [31:0] tms_s, tdi_s;
        logic tb, rb;
        src = 0;
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'h000A, 5'b00001, 5, 40, dc, nd, nr, tms_s, tdi_s, tb, rb);
        checks++; if (dc !== 17) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=17", dc); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL busy_done_pulses got=%0d exp=1", nd); end
        checks++; if (rb !== 1'b0) begin failures++; $display("FAIL busy_ready_low got=%b exp=0", rb); end
        checks++; if (TDO_DATA !== 16'h000A) begin failures++; $display("FAIL busy_tdo_data got=%h exp=000a", TDO_DATA); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL busy_idle_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_reset_mid_shift();
        int unsigned dc, nd, nr, late;
        logic [31:0] tms_s, tdi_s;
        logic tb, rb;
        src = 0;
        CMD_RST = 0; CMD_HDR = 0; CMD_IR = 0; CMD_TLR = 0;
        CMD_LEN = 4'd8; CMD_DATA = 16'h01FF; CHAN_SEL = 5'b00001; CMD_VALID = 1'b1;
        @(posedge FPGACLK); #1;
        CMD_VALID = 1'b0;
        repeat (19) @(posedge FPGACLK);
        #1;
        checks++; if (TCK !== 5'b00001) begin failures++; $display("FAIL mid_tck_high got=%b exp=00001", TCK); end
        RST_B = 1'b0;
        @(posedge FPGACLK); #1;
        checks++; if (TCK !== 5'b0) begin failures++; $display("FAIL mid_tck_reset got=%b exp=00000", TCK); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL mid_busy_reset got=%b exp=0", BUSY); end
        checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL mid_ready_reset got=%b exp=1", CMD_READY); end
        checks++; if (TDI !== 1'b0) begin failures++; $display("FAIL mid_tdi_reset got=%b exp=0", TDI); end
        RST_B = 1'b1;
        late = 0;
        for (int k = 0; k < 40; k++) begin
            if (DONE) late++;
            @(posedge FPGACLK); #1;
        end
        checks++; if (late !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", late); end
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0001, 5'b00000, 0, 10, dc, nd, nr, tms_s, tdi_s, tb, rb);
        checks++; if (dc !== 5) begin failures++; $display("FAIL nosel_done_cycle got=%0d exp=5", dc); end
        checks++; if (nr !== 0) begin failures++; $display("FAIL nosel_tck_rises got=%0d exp=0", nr); end
        checks++; if (TDO_DATA !== 16'h0) begin failures++; $display("FAIL nosel_tdo_data got=%h exp=0000", TDO_DATA); end
    endtask

    initial begin
        test_reset();
        test_dr_loopback();
        test_ir_full();
        test_tap_reset();
        test_busy_ignore();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
